golden_nonce_tracker: RTL and testbench

- Sits directly downstream of the hash comparator.
- Tracks which nonce each hash-out FIFO entry corresponds to by counting the comparator's pop strobes from a host-supplied base nonce.
- When the comparator flags a hash below target, latches the golden nonce and presents it to the host over a valid/ready handshake.
- Also reports nonce-space exhaustion and a busy indication to the control block.

---
 rtl/golden_nonce_tracker.sv | 205 ++++++++++++++++++++
 tb/tb_golden_nonce_tracker.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/golden_nonce_tracker.sv
// golden_nonce_tracker: maps comparator pops to nonces and reports the golden nonce to the host.
// Latency: 1 cycle from the result rising edge to nonce_valid (2 cycles after the comparator decides).
// Backpressure: nonce_valid/nonce_out are held until nonce_ready; stop never cancels a pending report.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - arm pulse; loads nonce_base and begins a job
//   stop              - abort request; ends the job without a report (unless one is already pending)
//   nonce_base        - first nonce of the job, sampled on start
//   hashout_fifo_re   - comparator pop strobe; each high cycle is one discarded hash
//   result            - comparator level result, 1 = hash below target
//   stop_ack_comp     - comparator drained / idle
//   nonce_valid       - golden nonce available (valid/ready with nonce_ready)
//   nonce_out         - golden nonce
//   nonce_ready       - host accepts nonce_out
//   exhausted         - nonce counter carried out of NONCE_W bits during this job (sticky to next start)
//   busy              - tracker is not IDLE
//
// Optional build macro GOLDEN_NONCE_STATS_EN adds:
//   hash_count[47:0]  - hashes examined while ARMED this job (pops plus the golden one), saturating
//   golden_count[15:0]- completed report handshakes since reset, saturating

module golden_nonce_tracker #(
    parameter int unsigned          NONCE_W    = 64,
    parameter logic [NONCE_W-1:0]   NONCE_STEP = NONCE_W'(1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [NONCE_W-1:0] nonce_base,
    input  logic               hashout_fifo_re,
    input  logic               result,
    input  logic               stop_ack_comp,
    output logic               nonce_valid,
    output logic [NONCE_W-1:0] nonce_out,
    input  logic               nonce_ready,
    output logic               exhausted,
    output logic               busy
`ifdef GOLDEN_NONCE_STATS_EN
    ,
    output logic [47:0]        hash_count,
    output logic [15:0]        golden_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ARMED      = 2'd1,
        S_REPORT     = 2'd2,
        S_WAIT_DRAIN = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [NONCE_W-1:0]   r_nonce_cnt;
    logic [NONCE_W-1:0]   w_nonce_cnt_nxt;
    logic [NONCE_W-1:0]   r_nonce_out;
    logic [NONCE_W-1:0]   w_nonce_out_nxt;
    logic                 r_nonce_valid;
    logic                 w_nonce_valid_nxt;
    logic                 r_exhausted;
    logic                 w_exhausted_nxt;
    logic                 r_result_d;
    logic                 r_start_mask;

    logic                 w_golden;
    logic                 w_load;
    logic                 w_count_hash;
    logic                 w_handshake;
    logic [NONCE_W:0]     w_sum;

    // result_d is cleared on start, so a result that is still high when the job
    // begins would otherwise look like a rising edge in the first ARMED cycle.
    // r_start_mask remembers the level seen on the start cycle and suppresses
    // that false edge; from the second ARMED cycle on, result_d covers it.
    assign w_golden = result & ~r_result_d & ~r_start_mask;

    // One extra bit catches the carry out of the nonce counter.
    assign w_sum = {1'b0, r_nonce_cnt} + {1'b0, NONCE_STEP};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_nonce_cnt   <= '0;
            r_nonce_out   <= '0;
            r_nonce_valid <= 1'b0;
            r_exhausted   <= 1'b0;
            r_result_d    <= 1'b0;
            r_start_mask  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_nonce_cnt   <= w_nonce_cnt_nxt;
            r_nonce_out   <= w_nonce_out_nxt;
            r_nonce_valid <= w_nonce_valid_nxt;
            r_exhausted   <= w_exhausted_nxt;
            r_result_d    <= w_load ? 1'b0 : result;
            r_start_mask  <= w_load & result;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_nonce_cnt_nxt   = r_nonce_cnt;
        w_nonce_out_nxt   = r_nonce_out;
        w_nonce_valid_nxt = r_nonce_valid;
        w_exhausted_nxt   = r_exhausted;
        w_load            = 1'b0;
        w_count_hash      = 1'b0;
        w_handshake       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                end
            end

            S_ARMED: begin
                if (stop) begin
                    w_state_nxt = S_WAIT_DRAIN;
                end else if (w_golden) begin
                    // A pop in the same cycle belongs to the golden hash itself,
                    // so the pre-increment count is the golden nonce.
                    w_nonce_out_nxt   = r_nonce_cnt;
                    w_nonce_valid_nxt = 1'b1;
                    w_count_hash      = 1'b1;
                    w_state_nxt       = S_REPORT;
                end else if (hashout_fifo_re) begin
                    w_nonce_cnt_nxt = w_sum[NONCE_W-1:0];
                    w_count_hash    = 1'b1;
                    if (w_sum[NONCE_W]) begin
                        w_exhausted_nxt = 1'b1;
                    end
                end
            end

            S_REPORT: begin
                // Pops here are comparator drains and stop is deferred until
                // the host takes the nonce.
                if (nonce_ready) begin
                    w_nonce_valid_nxt = 1'b0;
                    w_handshake       = 1'b1;
                    w_state_nxt       = S_WAIT_DRAIN;
                end
            end

            S_WAIT_DRAIN: begin
                if (stop_ack_comp) begin
                    if (start) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_nonce_cnt_nxt = nonce_base;
            w_exhausted_nxt = 1'b0;
            w_state_nxt     = S_ARMED;
        end
    end

    assign nonce_valid = r_nonce_valid;
    assign nonce_out   = r_nonce_out;
    assign exhausted   = r_exhausted;
    assign busy        = (r_state != S_IDLE);

`ifdef GOLDEN_NONCE_STATS_EN
    logic [47:0] r_hash_count;
    logic [15:0] r_golden_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hash_count   <= '0;
            r_golden_count <= '0;
        end else begin
            if (w_load) begin
                r_hash_count <= '0;
            end else if (w_count_hash && (r_hash_count != '1)) begin
                r_hash_count <= r_hash_count + 48'd1;
            end

            if (w_handshake && (r_golden_count != '1)) begin
                r_golden_count <= r_golden_count + 16'd1;
            end
        end
    end

    assign hash_count   = r_hash_count;
    assign golden_count = r_golden_count;
`else
    // Without the statistics counters these strobes have no consumer.
    logic w_stats_unused;
    assign w_stats_unused = w_count_hash | w_handshake;
`endif

endmodule

// File: tb/tb_golden_nonce_tracker.sv
// Bench for golden_nonce_tracker: a 64-bit/step-1 instance and an 8-bit/step-4 instance share stimulus.
// The reference model tracks each job as base + pops*STEP in wide arithmetic; wrap and exhaustion fall out of that sum.
// Directed scenarios first, then randomized traffic; outputs compared every cycle, #1 after the rising edge.

module tb_golden_nonce_tracker;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [63:0] base;
    logic [7:0]  base8;
    logic        pop;
    logic        res;
    logic        ready;
    logic        ack;

    logic        nv_a, ex_a, bz_a;
    logic [63:0] no_a;
    logic        nv_b, ex_b, bz_b;
    logic [7:0]  no_b;

`ifdef GOLDEN_NONCE_STATS_EN
    logic [47:0] hc_a, hc_b;
    logic [15:0] gc_a, gc_b;
`endif

    int n_chk;
    int n_fail;

    assign base8 = base[7:0];

    golden_nonce_tracker u_dut_a (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .nonce_base      (base),
        .hashout_fifo_re (pop),
        .result          (res),
        .stop_ack_comp   (ack),
        .nonce_valid     (nv_a),
        .nonce_out       (no_a),
        .nonce_ready     (ready),
        .exhausted       (ex_a),
        .busy            (bz_a)
`ifdef GOLDEN_NONCE_STATS_EN
        ,
        .hash_count      (hc_a),
        .golden_count    (gc_a)
`endif
    );

    golden_nonce_tracker #(
        .NONCE_W    (8),
        .NONCE_STEP (8'd4)
    ) u_dut_b (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .stop            (stop),
        .nonce_base      (base8),
        .hashout_fifo_re (pop),
        .result          (res),
        .stop_ack_comp   (ack),
        .nonce_valid     (nv_b),
        .nonce_out       (no_b),
        .nonce_ready     (ready),
        .exhausted       (ex_b),
        .busy            (bz_b)
`ifdef GOLDEN_NONCE_STATS_EN
        ,
        .hash_count      (hc_b),
        .golden_count    (gc_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Job phase: 0 no job, 1 searching, 2 holding a nonce for the host, 3 waiting for the comparator to drain.
    int           ph   [2];
    logic [127:0] mb   [2];   // job base nonce
    logic [127:0] npop [2];   // pops counted this job
    logic [63:0]  mout [2];
    logic         mval [2];
    logic         prev_res;
    logic [127:0] stp  [2];
    int           wid  [2];

    function automatic logic [127:0] job_sum(input int k);
        return mb[k] + npop[k] * stp[k];
    endfunction

    function automatic logic [63:0] wmask(input int k);
        logic [63:0] m;
        m = '1;
        return m >> (64 - wid[k]);
    endfunction

    task automatic model_tick();
        logic golden;
        logic [127:0] bk;
        golden = res & ~prev_res;
        for (int k = 0; k < 2; k++) begin
            bk = {64'd0, base & wmask(k)};
            if (rst) begin
                ph[k] = 0; mb[k] = '0; npop[k] = '0; mout[k] = '0; mval[k] = 1'b0;
            end else begin
                case (ph[k])
                    0: if (start) begin mb[k] = bk; npop[k] = '0; ph[k] = 1; end
                    1: begin
                        if (stop) ph[k] = 3;
                        else if (golden) begin
                            mout[k] = job_sum(k)[63:0] & wmask(k);
                            mval[k] = 1'b1;
                            ph[k]   = 2;
                        end else if (pop) npop[k] = npop[k] + 128'd1;
                    end
                    2: if (ready) begin mval[k] = 1'b0; ph[k] = 3; end
                    default: if (ack) begin
                        if (start) begin mb[k] = bk; npop[k] = '0; ph[k] = 1; end
                        else ph[k] = 0;
                    end
                endcase
            end
        end
        prev_res = rst ? 1'b0 : res;
    endtask

    // Advance one clock: update the model from the current inputs, then compare both DUTs.
    task automatic step();
        logic [127:0] s;
        model_tick();
        @(posedge clk);
        #1;
        s = job_sum(0);
        chk("a.valid", {63'd0, nv_a}, {63'd0, mval[0]});
        chk("a.nonce", no_a, mout[0]);
        chk("a.exhausted", {63'd0, ex_a}, {63'd0, (s >> 64) != 0});
        chk("a.busy", {63'd0, bz_a}, {63'd0, ph[0] != 0});
        s = job_sum(1);
        chk("b.valid", {63'd0, nv_b}, {63'd0, mval[1]});
        chk("b.nonce", {56'd0, no_b}, mout[1]);
        chk("b.exhausted", {63'd0, ex_b}, {63'd0, (s >> 8) != 0});
        chk("b.busy", {63'd0, bz_b}, {63'd0, ph[1] != 0});
    endtask

    task automatic drv(input logic st, input logic sp, input logic p, input logic r,
                       input logic rd, input logic a);
        start = st; stop = sp; pop = p; res = r; ready = rd; ack = a;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        stp[0] = 128'd1; stp[1] = 128'd4;
        wid[0] = 64;     wid[1] = 8;
        for (int k = 0; k < 2; k++) begin
            ph[k] = 0; mb[k] = '0; npop[k] = '0; mout[k] = '0; mval[k] = 1'b0;
        end
        prev_res = 1'b0;
        base = '0;
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        step(); step();
        chk("reset.valid", {63'd0, nv_a}, 64'd0);
        chk("reset.busy", {63'd0, bz_a}, 64'd0);
        rst = 1'b0;

        // Basic find
        base = 64'h100; drv(1, 0, 0, 0, 0, 0); step();
        drv(0, 0, 1, 0, 0, 0); repeat (5) step();
        drv(0, 0, 0, 1, 0, 0); step();
        chk("basic.valid", {63'd0, nv_a}, 64'd1);
        chk("basic.nonce", no_a, 64'h105);
        drv(0, 0, 0, 1, 1, 0); step();
        chk("basic.drop", {63'd0, nv_a}, 64'd0);
        chk("basic.busy_drain", {63'd0, bz_a}, 64'd1);
        drv(0, 0, 0, 0, 0, 1); step();
        chk("basic.idle", {63'd0, bz_a}, 64'd0);

        // Backpressure with stop and drain pops during the report
        base = 64'h2A; drv(1, 0, 0, 0, 0, 0); step();
        drv(0, 0, 0, 1, 0, 0); step();
        for (int i = 0; i < 20; i++) begin
            drv(0, 1, i[0], 1, 0, 0); step();
            chk("bp.valid_held", {63'd0, nv_a}, 64'd1);
            chk("bp.nonce_held", no_a, 64'h2A);
        end
        drv(0, 1, 0, 1, 1, 0); step();
        drv(0, 1, 0, 1, 0, 0); step();
        chk("bp.single_handshake", {63'd0, nv_a}, 64'd0);
        drv(0, 0, 0, 0, 0, 1); step();

        // Pop and golden edge in the same cycle
        base = 64'h10; drv(1, 0, 0, 0, 0, 0); step();
        drv(0, 0, 1, 0, 0, 0); repeat (3) step();
        drv(0, 0, 1, 1, 0, 0); step();
        chk("simul.nonce", no_a, 64'h13);
        drv(0, 0, 0, 1, 1, 0); step();
        drv(0, 0, 0, 0, 0, 1); step();

        // Abort, then a fresh job with an immediate result
        base = 64'h0; drv(1, 0, 0, 0, 0, 0); step();
        drv(0, 0, 1, 0, 0, 0); repeat (7) step();
        drv(0, 1, 0, 1, 0, 0); step();
        chk("abort.no_valid", {63'd0, nv_a}, 64'd0);
        drv(0, 1, 0, 0, 0, 1); step();
        chk("abort.idle", {63'd0, bz_a}, 64'd0);
        base = 64'h50; drv(1, 0, 0, 0, 0, 0); step();
        drv(0, 0, 0, 1, 0, 0); step();
        chk("abort.next_nonce", no_a, 64'h50);
        drv(0, 0, 0, 1, 1, 0); step();
        drv(0, 0, 0, 0, 0, 1); step();

        // Wrap on the 8-bit step-4 instance
        base = 64'hF8; drv(1, 0, 0, 0, 0, 0); step();
        drv(0, 0, 1, 0, 0, 0); repeat (3) step();
        chk("wrap.exhausted_b", {63'd0, ex_b}, 64'd1);
        chk("wrap.exhausted_a", {63'd0, ex_a}, 64'd0);
        drv(0, 0, 0, 1, 0, 0); step();
        chk("wrap.nonce_b", {56'd0, no_b}, 64'h04);
        chk("wrap.nonce_a", no_a, 64'hFB);
        drv(0, 0, 0, 1, 1, 0); step();
        drv(0, 0, 0, 0, 0, 1); step();
        chk("wrap.sticky_idle", {63'd0, ex_b}, 64'd1);
        base = 64'h20; drv(1, 0, 0, 0, 0, 0); step();
        chk("wrap.cleared", {63'd0, ex_b}, 64'd0);
        drv(0, 1, 0, 0, 0, 0); step();
        drv(0, 0, 0, 0, 0, 1); step();

        // Reset in the middle of a report, then result held high across start
        base = 64'h77; drv(1, 0, 0, 0, 0, 0); step();
        drv(0, 0, 0, 1, 0, 0); step();
        chk("rstrep.valid", {63'd0, nv_a}, 64'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rstrep.valid0", {63'd0, nv_a}, 64'd0);
        chk("rstrep.nonce0", no_a, 64'd0);
        chk("rstrep.busy0", {63'd0, bz_a}, 64'd0);
        drv(1, 0, 0, 1, 0, 0); step();
        drv(0, 0, 0, 1, 0, 0); repeat (4) step();
        chk("hold.no_report", {63'd0, nv_a}, 64'd0);
        drv(0, 0, 0, 0, 0, 0); step();
        drv(0, 0, 0, 1, 0, 0); step();
        chk("hold.report", {63'd0, nv_a}, 64'd1);
        chk("hold.nonce", no_a, 64'h77);
        drv(0, 0, 0, 1, 1, 0); step();
        drv(0, 0, 0, 0, 0, 1); step();

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 11) == 0);
            pop   = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) res = ~res;
            ready = ($urandom_range(0, 3) == 0);
            ack   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0)
                base = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
            else
                base = {$urandom, $urandom};
            step();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
